// File: rtl/fifo_burst_reader_if.sv
// Read-engine bundle: burst request channel, async-fifo read port and output word stream.
// master = burst engine side, slave = environment (requester, fifo, downstream sink).
interface fifo_burst_reader_if #(
   parameter int WORDSIZE = 8,
   parameter int LENW     = 8
) ();
   logic                req_valid;
   logic [LENW-1:0]     req_len;
   logic                req_ready;
   logic                fifo_empty;
   logic [WORDSIZE-1:0] fifo_rdata;
   logic                fifo_rd;
   logic                m_valid;
   logic                m_ready;
   logic [WORDSIZE-1:0] m_data;
   logic                m_last;

   modport master (
      input  req_valid, req_len, fifo_empty, fifo_rdata, m_ready,
      output req_ready, fifo_rd, m_valid, m_data, m_last
   );

   modport slave (
      output req_valid, req_len, fifo_empty, fifo_rdata, m_ready,
      input  req_ready, fifo_rd, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_burst_reader.sv
// Read-side burst engine for the async fifo: pops N words into a 2-entry skid buffer feeding a valid/ready stream.
// Optional empty-stall abort is compiled in with FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader #(
   parameter int WORDSIZE = 8,
   parameter int LENW     = 8,
   parameter int TIMEOUT  = 64
) (
   input  logic                 rclk,
   input  logic                 rst,
   fifo_burst_reader_if.master  bus,
   output logic                 done,
   output logic                 done_err,
   output logic [15:0]          words_rd
);

   typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

   state_t              state;
   logic [LENW-1:0]     remaining;
   logic                req_ready_q;
   logic                done_q;

   logic [1:0]          buf_cnt;
   logic                wr_ptr;
   logic                rd_ptr;
   logic [WORDSIZE-1:0] buf_data [2];
   logic                buf_last [2];

   logic                req_acc;
   logic                pop;
   logic                xfer;
   logic                buf_drained;
   logic                abort;

   assign req_acc = bus.req_valid && req_ready_q;
   assign xfer    = (buf_cnt != 2'd0) && bus.m_ready;

   // A full buffer may still pop when its head leaves on the same edge.
   assign pop = (state == READ) && !bus.fifo_empty && (remaining != '0) &&
                ((buf_cnt < 2'd2) || ((buf_cnt == 2'd2) && bus.m_ready));

   assign buf_drained = (buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && xfer);

   assign bus.req_ready = req_ready_q;
   assign bus.fifo_rd   = pop;
   assign bus.m_valid   = (buf_cnt != 2'd0);
   assign bus.m_data    = (buf_cnt != 2'd0) ? buf_data[rd_ptr] : '0;
   assign bus.m_last    = (buf_cnt != 2'd0) ? buf_last[rd_ptr] : 1'b0;
   assign done          = done_q;

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         remaining   <= '0;
         req_ready_q <= 1'b1;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (req_acc) begin
                  remaining   <= bus.req_len;
                  req_ready_q <= 1'b0;
                  if (bus.req_len == '0) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end else begin
                     state <= READ;
                  end
               end
            end
            READ: begin
               if (abort) begin
                  remaining <= '0;
                  state     <= FLUSH;
               end else if (pop) begin
                  remaining <= remaining - LENW'(1);
                  if (remaining == LENW'(1)) state <= FLUSH;
               end
            end
            // Leave FLUSH on the edge the last buffered word is accepted so done follows it directly.
            FLUSH: begin
               if (buf_drained) begin
                  state  <= DONE;
                  done_q <= 1'b1;
               end
            end
            DONE: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         buf_cnt  <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
         words_rd <= 16'd0;
      end else begin
         if (pop) begin
            wr_ptr   <= ~wr_ptr;
            words_rd <= words_rd + 16'd1;
         end
         if (xfer) rd_ptr <= ~rd_ptr;
         case ({pop, xfer})
            2'b10:   buf_cnt <= buf_cnt + 2'd1;
            2'b01:   buf_cnt <= buf_cnt - 2'd1;
            default: buf_cnt <= buf_cnt;
         endcase
      end
   end

   // Buffer storage is plain data; occupancy and pointers alone say what is valid.
   always_ff @(posedge rclk) begin
      if (pop) begin
         buf_data[wr_ptr] <= bus.fifo_rdata;
         buf_last[wr_ptr] <= (remaining == LENW'(1));
      end
   end

`ifdef FIFO_RD_TIMEOUT_EN
   localparam int STALL_W = $clog2(TIMEOUT + 1);

   logic [STALL_W-1:0] stall_cnt;
   logic               err_q;

   assign abort = (state == READ) && bus.fifo_empty &&
                  (stall_cnt == STALL_W'(TIMEOUT - 1));

   always_ff @(posedge rclk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
         err_q     <= 1'b0;
      end else begin
         if ((state != READ) || pop || abort) begin
            stall_cnt <= '0;
         end else if (bus.fifo_empty) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
         end
         if (abort) begin
            err_q <= 1'b1;
         end else if (req_acc) begin
            err_q <= 1'b0;
         end
      end
   end

   assign done_err = done_q & err_q;
`else
   // Without the stall limit a burst can only end normally; TIMEOUT has no effect here.
   localparam bit TIMEOUT_SET = (TIMEOUT != 0);

   assign abort    = 1'b0;
   assign done_err = done_q & TIMEOUT_SET & 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: behavioural fifo, negedge stream/handshake monitor, hand-computed expectations.
`timescale 1ns/1ps
module tb_fifo_burst_reader;
   localparam int WS = 8;
   localparam int LW = 8;
   localparam int TO = 8;

   logic        rclk = 1'b0;
   logic        rst  = 1'b0;
   logic        done;
   logic        done_err;
   logic [15:0] words_rd;

   fifo_burst_reader_if #(.WORDSIZE(WS), .LENW(LW)) bus ();

   fifo_burst_reader #(.WORDSIZE(WS), .LENW(LW), .TIMEOUT(TO)) dut (
      .rclk     (rclk),
      .rst      (rst),
      .bus      (bus),
      .done     (done),
      .done_err (done_err),
      .words_rd (words_rd)
   );

   always #5 rclk = ~rclk;

   function automatic logic [7:0] ix(input int i);
      return i[7:0];
   endfunction

   // Behavioural fifo: driver appends at fwr, this process alone advances frd.
   logic [WS-1:0] fmem [256];
   int unsigned   fwr = 0;
   int unsigned   frd = 0;
   logic          hold_empty = 1'b0;
   logic          rd_seen = 1'b0;

   initial begin
      forever begin
         bus.fifo_empty = hold_empty || (frd == fwr);
         bus.fifo_rdata = fmem[frd[7:0]];
         @(posedge rclk);
         #1;
         if (rd_seen && (frd != fwr)) frd = frd + 1;
      end
   end

   // Monitor: values at negedge are the ones the next rising edge acts on.
   int            cyc = 0;
   int            rd_n = 0;
   int            rd_empty_n = 0;
   int            vld_n = 0;
   int            out_n = 0;
   int            done_n = 0;
   int            err_n = 0;
   int            done_cyc = 0;
   int            acc_cyc = 0;
   int            rd_cyc  [256];
   int            out_cyc [256];
   logic [WS-1:0] out_data [256];
   logic          out_last [256];

   always @(negedge rclk) begin
      cyc     <= cyc + 1;
      rd_seen <= bus.fifo_rd;
      if (bus.fifo_rd) begin
         rd_cyc[ix(rd_n)] <= cyc;
         rd_n             <= rd_n + 1;
      end
      if (bus.fifo_rd && bus.fifo_empty) rd_empty_n <= rd_empty_n + 1;
      if (bus.m_valid) vld_n <= vld_n + 1;
      if (bus.m_valid && bus.m_ready) begin
         out_data[ix(out_n)] <= bus.m_data;
         out_last[ix(out_n)] <= bus.m_last;
         out_cyc[ix(out_n)]  <= cyc;
         out_n               <= out_n + 1;
      end
      if (done) begin
         done_n   <= done_n + 1;
         done_cyc <= cyc;
         if (done_err) err_n <= err_n + 1;
      end
      if (bus.req_valid && bus.req_ready) acc_cyc <= cyc;
   end

   int errs   = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge rclk);
         #2;
      end
   endtask

   task automatic push(input logic [WS-1:0] d);
      fmem[fwr[7:0]] = d;
      fwr = fwr + 1;
   endtask

   task automatic request(input int len);
      bus.req_valid = 1'b1;
      bus.req_len   = LW'(len);
      step();
      bus.req_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int base, input int limit);
      int n;
      n = 0;
      while ((done_n == base) && (n < limit)) begin
         step();
         n++;
      end
      check({tag, "_done_seen"}, 32'(done_n - base), 32'd1);
   endtask

   task automatic check_burst(input string tag, input int base, input int cnt,
                              input logic [WS-1:0] first, input bit want_last);
      check({tag, "_words"}, 32'(out_n - base), 32'(cnt));
      for (int i = 0; i < cnt; i++) begin
         check($sformatf("%s_data%0d", tag, i), 32'(out_data[ix(base + i)]), 32'(first + WS'(i)));
         check($sformatf("%s_last%0d", tag, i), 32'(out_last[ix(base + i)]),
               32'(want_last && (i == cnt - 1)));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int         ob;
      int         rb;
      int         db;
      int         vb;
      int         reb;
      int         eb;
      int         d;
      logic [7:0] pat;

      pat           = 8'b0110_1001;
      bus.req_valid = 1'b0;
      bus.req_len   = '0;
      bus.m_ready   = 1'b0;
      step(2);

      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_m_valid",   32'(bus.m_valid),   32'd0);
      check("rst_m_data",    32'(bus.m_data),    32'd0);
      check("rst_m_last",    32'(bus.m_last),    32'd0);
      check("rst_fifo_rd",   32'(bus.fifo_rd),   32'd0);
      check("rst_done",      32'(done),          32'd0);
      check("rst_done_err",  32'(done_err),      32'd0);
      check("rst_words_rd",  32'(words_rd),      32'd0);
      rst = 1'b1;
      step(2);

      // Burst of 4 with the sink always ready.
      ob = out_n; rb = rd_n; db = done_n; eb = err_n;
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      bus.m_ready = 1'b1;
      step();
      request(4);
      wait_done("t1", db, 30);
      check("t1_pops", 32'(rd_n - rb), 32'd4);
      check("t1_pops_back_to_back", 32'(rd_cyc[ix(rb + 3)] - rd_cyc[ix(rb)]), 32'd3);
      check("t1_latency", 32'(out_cyc[ix(ob)] - rd_cyc[ix(rb)]), 32'd1);
      check("t1_out_back_to_back", 32'(out_cyc[ix(ob + 3)] - out_cyc[ix(ob)]), 32'd3);
      check_burst("t1", ob, 4, 8'hA0, 1'b1);
      check("t1_done_after_last", 32'(done_cyc - out_cyc[ix(ob + 3)]), 32'd1);
      check("t1_done_err", 32'(err_n - eb), 32'd0);
      check("t1_words_rd", 32'(words_rd), 32'd4);
      check("t1_req_ready", 32'(bus.req_ready), 32'd1);

      // Burst of 3 against a stalled sink: buffer fills after two pops.
      ob = out_n; rb = rd_n; db = done_n;
      for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
      bus.m_ready = 1'b0;
      step();
      request(3);
      step(5);
      check("t2_pops_while_stalled", 32'(rd_n - rb), 32'd2);
      check("t2_fifo_rd_blocked", 32'(bus.fifo_rd), 32'd0);
      check("t2_req_ready_busy", 32'(bus.req_ready), 32'd0);
      check("t2_head_valid", 32'(bus.m_valid), 32'd1);
      check("t2_head_data", 32'(bus.m_data), 32'h30);
      bus.m_ready = 1'b1;
      wait_done("t2", db, 30);
      check("t2_pops", 32'(rd_n - rb), 32'd3);
      check_burst("t2", ob, 3, 8'h30, 1'b1);
      check("t2_words_rd", 32'(words_rd), 32'd7);

      // Burst of 5 while the fifo flickers empty.
      ob = out_n; rb = rd_n; db = done_n; reb = rd_empty_n;
      for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
      step();
      request(5);
      for (int i = 0; (i < 60) && (done_n == db); i++) begin
         hold_empty = pat[i % 8];
         step();
      end
      hold_empty = 1'b0;
      check("t3_done_seen", 32'(done_n - db), 32'd1);
      check("t3_rd_while_empty", 32'(rd_empty_n - reb), 32'd0);
      check("t3_pops", 32'(rd_n - rb), 32'd5);
      check_burst("t3", ob, 5, 8'h50, 1'b1);
      check("t3_words_rd", 32'(words_rd), 32'd12);

      // Zero-length request.
      ob = out_n; rb = rd_n; db = done_n; vb = vld_n; eb = err_n;
      request(0);
      step(4);
      d = done_cyc - acc_cyc;
      check("t4_no_pop", 32'(rd_n - rb), 32'd0);
      check("t4_no_valid", 32'(vld_n - vb), 32'd0);
      check("t4_one_done", 32'(done_n - db), 32'd1);
      check("t4_done_err", 32'(err_n - eb), 32'd0);
      check("t4_done_timing", 32'((d >= 1) && (d <= 2)), 32'd1);

      // Reset mid-burst with the buffer full, then a clean burst.
      rb = rd_n; db = done_n;
      for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
      bus.m_ready = 1'b0;
      step();
      request(6);
      step(3);
      check("t5_pops_before_rst", 32'(rd_n - rb), 32'd2);
      check("t5_full_valid", 32'(bus.m_valid), 32'd1);
      rst = 1'b0;
      #1;
      check("t5_rst_m_valid", 32'(bus.m_valid), 32'd0);
      check("t5_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("t5_rst_words_rd", 32'(words_rd), 32'd0);
      check("t5_rst_fifo_rd", 32'(bus.fifo_rd), 32'd0);
      step(2);
      rst = 1'b1;
      step(2);
      check("t5_no_done", 32'(done_n - db), 32'd0);
      ob = out_n; db = done_n; eb = err_n;
      bus.m_ready = 1'b1;
      request(4);
      wait_done("t5", db, 30);
      check_burst("t5", ob, 4, 8'h62, 1'b1);
      check("t5_words_rd", 32'(words_rd), 32'd4);
      check("t5_done_err", 32'(err_n - eb), 32'd0);

`ifdef FIFO_RD_TIMEOUT_EN
      // Only 2 of 4 words ever arrive: stall limit aborts the burst.
      ob = out_n; rb = rd_n; db = done_n; eb = err_n;
      push(8'h70);
      push(8'h71);
      step();
      request(4);
      wait_done("t6", db, 60);
      d = done_cyc - rd_cyc[ix(rb + 1)];
      check("t6_pops", 32'(rd_n - rb), 32'd2);
      check_burst("t6", ob, 2, 8'h70, 1'b0);
      check("t6_done_err", 32'(err_n - eb), 32'd1);
      check("t6_abort_timing", 32'((d >= TO + 1) && (d <= TO + 2)), 32'd1);
      check("t6_words_rd", 32'(words_rd), 32'd6);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
